// File: rtl/mem_responder.sv
// mem_responder: SRAM-backed responder for the accel mem_req/mem_wr/mem_rd port.
// Define MEM_RESP_STALL_EN to hide read beats pseudo-randomly via an 8-bit LFSR.
module mem_responder #(
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 64,
   parameter int MEM_DATA_BITS = 64,
   parameter int DEPTH_BITS    = 10
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     mem_req_valid,
   input  logic                     mem_req_opcode,
   input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
   input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
   input  logic                     mem_wr_valid,
   input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
   output logic                     mem_rd_valid,
   output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
   input  logic                     mem_rd_ready,
   output logic                     busy,
   output logic                     err_drop
);

   localparam int DEPTH = 2 ** DEPTH_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ
   } state_t;

   state_t                   state;
   logic [DEPTH_BITS-1:0]    ptr;
   logic [MEM_LEN_BITS-1:0]  cnt;
   logic [MEM_LEN_BITS:0]    iss;
   logic [MEM_DATA_BITS-1:0] mem [DEPTH];
   logic [MEM_DATA_BITS-1:0] fifo [2];
   logic                     wp;
   logic                     rp;
   logic [1:0]               count;
   logic                     show;
   logic                     pop;
   logic                     issue;
   logic                     wr_beat;
   logic                     unused_addr;

   assign unused_addr = ^{mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS+3],
                          mem_req_addr[2:0]};

`ifdef MEM_RESP_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign show = (count != 2'd0) && !lfsr[0];
`else
   assign show = (count != 2'd0);
`endif

   // The FIFO entry itself is the SRAM read register, so a read issued
   // in cycle n is presented in cycle n+1.
   assign issue   = (state == READ) && (iss != '0) && (count != 2'd2);
   assign pop     = (state == READ) && show && mem_rd_ready;
   assign wr_beat = (state == WRITE) && mem_wr_valid;

   assign mem_rd_valid = show;
   assign mem_rd_bits  = fifo[rp];

   always_ff @(posedge clock) begin
      if (wr_beat) begin
         mem[ptr] <= mem_wr_bits;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fifo[0] <= '0;
         fifo[1] <= '0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (issue) begin
            fifo[wp] <= mem[ptr];
            wp       <= ~wp;
         end
         if (pop) begin
            rp <= ~rp;
         end
         unique case ({issue, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         iss      <= '0;
         busy     <= 1'b0;
         err_drop <= 1'b0;
      end else begin
         if (mem_req_valid && (state != IDLE)) begin
            err_drop <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (mem_req_valid) begin
                  ptr   <= mem_req_addr[DEPTH_BITS+2:3];
                  cnt   <= mem_req_len;
                  iss   <= {1'b0, mem_req_len} + (MEM_LEN_BITS+1)'(1);
                  busy  <= 1'b1;
                  state <= mem_req_opcode ? WRITE : READ;
               end
            end
            WRITE: begin
               if (mem_wr_valid) begin
                  ptr <= ptr + DEPTH_BITS'(1);
                  cnt <= cnt - MEM_LEN_BITS'(1);
                  if (cnt == '0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  ptr <= ptr + DEPTH_BITS'(1);
                  iss <= iss - (MEM_LEN_BITS+1)'(1);
               end
               if (pop) begin
                  cnt <= cnt - MEM_LEN_BITS'(1);
                  if (cnt == '0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, table-driven bench for mem_responder.
// Uses DEPTH_BITS=4 so that wrap and aliasing are reachable.
module tb_mem_responder;

   logic        clock;
   logic        reset;
   logic        mem_req_valid;
   logic        mem_req_opcode;
   logic [7:0]  mem_req_len;
   logic [63:0] mem_req_addr;
   logic        mem_wr_valid;
   logic [63:0] mem_wr_bits;
   logic        mem_rd_valid;
   logic [63:0] mem_rd_bits;
   logic        mem_rd_ready;
   logic        busy;
   logic        err_drop;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ready;
      logic        valid;
      logic        cb;
      logic [63:0] bits;
      logic        busy;
   } vec_t;

   vec_t        tab[$];
   logic [63:0] wdata[$];

   mem_responder #(
      .MEM_LEN_BITS (8),
      .MEM_ADDR_BITS(64),
      .MEM_DATA_BITS(64),
      .DEPTH_BITS   (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_req_valid (mem_req_valid),
      .mem_req_opcode(mem_req_opcode),
      .mem_req_len   (mem_req_len),
      .mem_req_addr  (mem_req_addr),
      .mem_wr_valid  (mem_wr_valid),
      .mem_wr_bits   (mem_wr_bits),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_bits   (mem_rd_bits),
      .mem_rd_ready  (mem_rd_ready),
      .busy          (busy),
      .err_drop      (err_drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef MEM_RESP_STALL_EN
   logic [7:0] lfsr_m;

   always @(posedge clock or negedge reset) begin
      if (!reset) lfsr_m <= 8'hA5;
      else lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
   end
`endif

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic v, input logic cb,
                               input logic [63:0] b, input logic bs);
      tab.push_back('{ready: r, valid: v, cb: cb, bits: b, busy: bs});
   endfunction

   task automatic start_req(input logic op, input int len,
                            input logic [63:0] addr);
      @(negedge clock);
      mem_req_valid  = 1'b1;
      mem_req_opcode = op;
      mem_req_len    = 8'(len);
      mem_req_addr   = addr;
      mem_wr_valid   = op;
      mem_wr_bits    = 64'hBAD0_BAD0;
      @(negedge clock);
      mem_req_valid  = 1'b0;
      mem_wr_valid   = 1'b0;
   endtask

   task automatic run_tab(input string name);
      foreach (tab[i]) begin
         chk({name, " valid"}, 64'(mem_rd_valid), 64'(tab[i].valid));
         if (tab[i].valid && tab[i].cb)
            chk({name, " bits"}, mem_rd_bits, tab[i].bits);
         chk({name, " busy"}, 64'(busy), 64'(tab[i].busy));
         mem_rd_ready = tab[i].ready;
         @(negedge clock);
      end
      mem_rd_ready = 1'b0;
   endtask

   task automatic write_burst(input logic [63:0] addr);
      start_req(1'b1, wdata.size() - 1, addr);
      foreach (wdata[i]) begin
         chk("wr busy", 64'(busy), 64'd1);
         mem_wr_valid = 1'b1;
         mem_wr_bits  = wdata[i];
         @(negedge clock);
      end
      mem_wr_valid = 1'b0;
      chk("wr end busy", 64'(busy), 64'd0);
   endtask

   task automatic read_stream(input logic [63:0] addr, input string name);
      tab.delete();
      add(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
      foreach (wdata[i]) add(1'b1, 1'b1, 1'b1, wdata[i], 1'b1);
      add(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
      start_req(1'b0, wdata.size() - 1, addr);
      run_tab(name);
   endtask

   task automatic read_one(input logic [63:0] addr, input logic [63:0] exp,
                           input string name);
      wdata = '{exp};
      read_stream(addr, name);
   endtask

   initial begin
      reset          = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_opcode = 1'b0;
      mem_req_len    = 8'd0;
      mem_req_addr   = 64'd0;
      mem_wr_valid   = 1'b0;
      mem_wr_bits    = 64'd0;
      mem_rd_ready   = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst valid", 64'(mem_rd_valid), 64'd0);
      chk("rst bits", mem_rd_bits, 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst err", 64'(err_drop), 64'd0);

`ifdef MEM_RESP_STALL_EN
      begin
         int n;
         n = 0;
         wdata = '{64'h11, 64'h22, 64'h33, 64'h44};
         write_burst(64'h100);
         start_req(1'b0, 3, 64'h100);
         mem_rd_ready = 1'b1;
         for (int c = 0; c < 200 && busy; c++) begin
            if (lfsr_m[0]) chk("stall hide", 64'(mem_rd_valid), 64'd0);
            if (mem_rd_valid && n < 4) begin
               chk("stall bits", mem_rd_bits, wdata[n]);
               n++;
            end
            @(negedge clock);
         end
         mem_rd_ready = 1'b0;
         chk("stall pops", 64'(n), 64'd4);
         chk("stall done", 64'(busy), 64'd0);
      end
`else
      tab.delete();
      add(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
      add(1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
      start_req(1'b0, 0, 64'h0);
      run_tab("rd0");

      wdata = '{64'h11, 64'h22, 64'h33, 64'h44};
      write_burst(64'h100);
      read_stream(64'h100, "wr_rd");

      // Ready toggles 1,0,1,0 from the issue cycle onward.
      tab.delete();
      add(1'b1, 1'b0, 1'b0, 64'h00, 1'b1);
      add(1'b0, 1'b1, 1'b1, 64'h11, 1'b1);
      add(1'b1, 1'b1, 1'b1, 64'h11, 1'b1);
      add(1'b0, 1'b1, 1'b1, 64'h22, 1'b1);
      add(1'b1, 1'b1, 1'b1, 64'h22, 1'b1);
      add(1'b0, 1'b1, 1'b1, 64'h33, 1'b1);
      add(1'b1, 1'b1, 1'b1, 64'h33, 1'b1);
      add(1'b0, 1'b1, 1'b1, 64'h44, 1'b1);
      add(1'b1, 1'b1, 1'b1, 64'h44, 1'b1);
      add(1'b0, 1'b0, 1'b0, 64'h00, 1'b0);
      start_req(1'b0, 3, 64'h100);
      run_tab("bp");

      wdata = '{64'hAA, 64'hBB};
      write_burst(64'h78);
      read_one(64'h0, 64'hBB, "wrap0");
      read_one(64'h400, 64'hBB, "alias");
      read_one(64'h78, 64'hAA, "wrap15");

      wdata = '{64'h1000, 64'h1001, 64'h1002, 64'h1003,
                64'h1004, 64'h1005, 64'h1006, 64'h1007};
      write_burst(64'h100);
      start_req(1'b0, 7, 64'h100);
      for (int k = 0; k < 10; k++) begin
         chk("busy_req valid", 64'(mem_rd_valid), 64'(k >= 1 && k <= 8));
         if (k >= 1 && k <= 8) chk("busy_req bits", mem_rd_bits, wdata[k-1]);
         chk("busy_req busy", 64'(busy), 64'(k <= 8));
         chk("busy_req err", 64'(err_drop), 64'(k >= 3));
         mem_rd_ready   = 1'b1;
         mem_req_valid  = (k == 2);
         mem_req_opcode = 1'b1;
         mem_req_len    = 8'd0;
         mem_req_addr   = 64'h100;
         mem_wr_valid   = (k == 2 || k == 3);
         mem_wr_bits    = 64'hDEAD;
         @(negedge clock);
      end
      mem_req_valid = 1'b0;
      mem_wr_valid  = 1'b0;
      mem_rd_ready  = 1'b0;
      chk("err sticky", 64'(err_drop), 64'd1);

      start_req(1'b0, 7, 64'h100);
      for (int k = 0; k < 4; k++) begin
         chk("mid valid", 64'(mem_rd_valid), 64'(k >= 1));
         if (k >= 1) chk("mid bits", mem_rd_bits, wdata[k-1]);
         mem_rd_ready = 1'b1;
         if (k < 3) @(negedge clock);
      end
      reset = 1'b0;
      #1;
      chk("mid rst valid", 64'(mem_rd_valid), 64'd0);
      chk("mid rst bits", mem_rd_bits, 64'd0);
      chk("mid rst busy", 64'(busy), 64'd0);
      chk("mid rst err", 64'(err_drop), 64'd0);
      mem_rd_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("post rst busy", 64'(busy), 64'd0);
      chk("post rst valid", 64'(mem_rd_valid), 64'd0);
      read_stream(64'h100, "reread");
      chk("reread err", 64'(err_drop), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable memory responder for the accelerator's memory-request interface (mem_req / mem_wr / mem_rd). It sits on the responder side of the `accel` memory port, in the position the DPI memory model occupies in simulation, and backs requests with an on-chip single-port SRAM. This gives FPGA and emulation builds a self-contained memory with the same protocol the accelerator already drives.

## Interface
- MEM_LEN_BITS, 8: burst length field width; a burst is len+1 beats.
- MEM_ADDR_BITS, 64: byte address width.
- MEM_DATA_BITS, 64: beat width; beats are 8-byte aligned.
- DEPTH_BITS, 10: SRAM depth is 2^DEPTH_BITS words.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request strobe; accepted only in IDLE.
- mem_req_opcode  in  1  0 = read, 1 = write.
- mem_req_len  in  MEM_LEN_BITS  beats minus one.
- mem_req_addr  in  MEM_ADDR_BITS  byte address of the first beat.
- mem_wr_valid  in  1  write beat strobe; no backpressure, so every beat in WRITE state is taken.
- mem_wr_bits  in  MEM_DATA_BITS  write beat data.
- mem_rd_valid  out  MEM_DATA_BITS-independent 1  read beat valid.
- mem_rd_bits  out  MEM_DATA_BITS  read beat data.
- mem_rd_ready  in  1  accelerator accepts a read beat.
- busy  out  1  high in any state other than IDLE.
- err_drop  out  1  sticky flag: a request arrived while busy.

## Operation
- The word index is mem_req_addr[DEPTH_BITS+2:3].
  - Upper address bits are ignored (aliasing).
  - Address bits [2:0] are ignored.
- The word pointer increments per beat modulo 2^DEPTH_BITS, so bursts wrap to word 0.
- A beat counter loads mem_req_len and decrements per beat; the last beat is the one where the counter is 0.
- State machine:
  - IDLE: mem_req_valid high latches the address and length. Go to WRITE if opcode is 1, otherwise go to READ.
  - WRITE: each cycle with mem_wr_valid high writes mem_wr_bits to SRAM[ptr] and advances the pointer. Go to IDLE after the last beat.
  - READ: SRAM reads are issued into a 2-entry output FIFO whenever the FIFO has space, counting occupancy plus the read in flight. mem_rd_valid is high when the FIFO is not empty. A beat pops when mem_rd_valid and mem_rd_ready are both high. Go to IDLE after the last beat pops.
- mem_rd_valid and mem_rd_bits stay stable while mem_rd_ready is low.
- No more than len+1 SRAM reads are issued per burst.
- mem_req_valid in WRITE or READ: the request is ignored, err_drop is set, and the active burst is unaffected.
- mem_wr_valid outside WRITE, including the acceptance cycle: ignored. No flag is raised.
- Reset asserted:
  - State goes to IDLE; FIFO, counters and pointer clear.
  - SRAM contents are not reset and are retained across reset.

## Timing
- Reset values: mem_rd_valid 0, mem_rd_bits 0, busy 0, err_drop 0.
- A request accepted at cycle t gives busy = 1 from t+1.
- Write: beats are accepted from t+1. Data is visible to a read request accepted in the cycle after the last write beat.
- Read:
  - SRAM read is issued at t+1.
  - First mem_rd_valid is at t+2.
  - With mem_rd_ready held high, beats stream one per cycle with no bubbles.
- End of burst: busy drops in the cycle after the last beat, either the last write beat or the last read pop. A new request is accepted in that cycle.
- Minimum read burst (len = 0) occupies t to t+2 with ready high; IDLE again at t+3.

## Configuration
- MEM_RESP_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5, reset to the seed) advances every cycle.
  - mem_rd_valid is forced low in cycles where lfsr[0] = 1. Pops occur only when valid is shown.
  - Used to stress accelerator read backpressure handling.
- Not defined: no LFSR; mem_rd_valid is exactly FIFO not-empty.

## Test plan
- Reset: hold reset low 3 cycles, release. All outputs are 0 and busy = 0. Read len=0 at 0x0 completes (contents unchecked).
- Write then read:
  - Write len=3 at 0x100 with beats 0x11, 0x22, 0x33, 0x44.
  - Read len=3 at 0x100 with ready=1: the same 4 beats in order; first valid at t+2, then consecutive cycles; busy low at the cycle after the 4th pop.
- Backpressure:
  - Same read with mem_rd_ready pattern 1,0,1,0,...
  - Beats arrive in order 0x11..0x44; mem_rd_bits is held constant during every stall; exactly 4 pops.
- Wrap:
  - DEPTH_BITS=4. Write len=1 at 0x78 with 0xAA, 0xBB; 0xBB lands at word 0.
  - Read len=0 at 0x0 returns 0xBB. Read len=0 at 0x400 (alias) also returns 0xBB.
- Request while busy:
  - During a read burst with len=7, pulse a write request.
  - err_drop becomes 1 and stays 1 until reset; all 8 read beats are correct; no memory changed.
- Reset mid-read:
  - Assert reset after 2 of 8 beats: mem_rd_valid drops immediately (asynchronously) and the block is in IDLE after release.
  - A re-issued read returns the previously written data.
- Build with MEM_RESP_STALL_EN: repeat the write-then-read scenario. Data is correct and valid is low in exactly the cycles where lfsr[0] = 1.
